mul_seq_16: RTL

- Sequential unsigned 16x16 -> 32-bit shift-add multiplier; one partial-product add per clock.
- Drives the 16-bit ripple-carry adder add_rca_16 (operands and carry-in) and consumes its sum/carry-out every cycle.
- Sits between the operand-issue logic and the datapath result bus.
- Uses a valid/ready handshake on both sides.

---
 rtl/mul_pkg.sv | 16 +
 rtl/add_rca_16.sv | 28 ++
 rtl/mul_seq_16.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   mul_state_e : control FSM encoding (IDLE / RUN / DONE)
//   MUL_WIDTH   : operand width supported by mul_seq_16
//   MUL_STEPS   : number of shift-add steps per operation
package mul_pkg;

  localparam int MUL_WIDTH = 16;
  localparam int MUL_STEPS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/add_rca_16.sv
// 16-bit ripple-carry adder used as the per-step adder of mul_seq_16.
// Ports:
//   a, b   : 16-bit addends
//   c_in   : carry in
//   sum    : 16-bit sum
//   c_out  : carry out of bit 15
module add_rca_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        c_out
);

  logic [16:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = c_in;
    for (int i = 0; i < 16; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    c_out = carry[16];
  end

endmodule

// File: rtl/mul_seq_16.sv
// Sequential unsigned 16x16 -> 32-bit shift-add multiplier, one partial
// product add per clock through add_rca_16.
//
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake, a = multiplicand, b = multiplier
//   out_valid / out_ready: result handshake, product = a*b
//   busy                 : high while the FSM is in RUN
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. A source holds its data while valid is high and ready is low;
// out_valid and product stay stable until out_ready is seen. in_ready is
// only high in IDLE, so there is always a one-cycle bubble after DONE.
//
// Build option: define MUL_ZERO_SKIP_EN to send an operation with a zero
// operand straight from the accepting edge to DONE with product 0.
//
// Latency: out_valid rises 16 edges after the accepting edge (immediately
// after the accepting edge for zero-skip operations).
module mul_seq_16
  import mul_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  generate
    if (WIDTH != MUL_WIDTH) begin : g_width_check
      $error("mul_seq_16: only WIDTH=16 is supported");
    end
  endgenerate

  mul_state_e        state;
  mul_state_e        state_nxt;
  logic              init_done;   // low until the first edge after reset release
  logic [WIDTH-1:0]  mcand;
  logic [WIDTH-1:0]  acc_hi;
  logic [WIDTH-1:0]  acc_lo;      // holds the unconsumed multiplier bits
  logic [CNT_W-1:0]  cnt;
  logic [WIDTH-1:0]  pp;
  logic [WIDTH-1:0]  sum;
  logic              c_out;
  logic              accept;
  logic              zero_op;
  logic              last_step;

`ifdef MUL_ZERO_SKIP_EN
  assign zero_op = (a == '0) || (b == '0);
`else
  assign zero_op = 1'b0;
`endif

  // Partial product selected by the current LSB of the multiplier.
  assign pp = acc_lo[0] ? mcand : '0;

  add_rca_16 u_step_add (
    .a     (acc_hi),
    .b     (pp),
    .c_in  (1'b0),
    .sum   (sum),
    .c_out (c_out)
  );

  assign accept    = in_valid && in_ready;
  assign last_step = (state == RUN) && (cnt == CNT_W'(MUL_STEPS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = init_done;
        if (in_valid && init_done) begin
          state_nxt = zero_op ? DONE : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_step) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_done <= 1'b0;
      mcand     <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      cnt       <= '0;
    end else begin
      init_done <= 1'b1;
      if (accept) begin
        mcand  <= zero_op ? '0 : a;
        acc_hi <= '0;
        acc_lo <= zero_op ? '0 : b;
        cnt    <= '0;
      end else if (state == RUN) begin
        // Shift the 33-bit {c_out, sum, acc_lo} right by one; the carry
        // lands in acc_hi[15] so no step can overflow.
        acc_hi <= {c_out, sum[WIDTH-1:1]};
        acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
        cnt    <= cnt + 1'b1;
      end
    end
  end

  assign product = out_valid ? {acc_hi, acc_lo} : '0;

endmodule
